kgp_risc_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the KGP-RISC decode/register-file stage.
- Holds the PC and drives a synchronous (1-cycle read latency) instruction memory.
- Delivers a registered instruction/PC pair with a valid flag.
- Handles stall back-pressure via a one-entry skid register, branch/jump redirects with squash of in-flight fetches, and halt.

---
 rtl/kgp_risc_fetch.sv | 102 ++++++++++
 tb/tb_kgp_risc_fetch.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kgp_risc_fetch.sv
// KGP-RISC instruction-fetch stage: PC, synchronous IMEM interface, one-entry skid,
// redirect squash, halt, misalignment flag and delivered-instruction counter.
module kgp_risc_fetch #(
    parameter int          IMEM_AW  = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    output logic               misalign_err,
    output logic [31:0]        fetch_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] pending_pc;
    logic        pending;
    logic [31:0] skid_data;
    logic [31:0] skid_pc;
    logic        skid_valid;

    assign imem_en   = (state == ST_RUN) && !rst && !stall && !redirect_valid && !halt;
    assign imem_addr = fetch_pc[IMEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            fetch_pc     <= RESET_PC;
            pending      <= 1'b0;
            pending_pc   <= '0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            skid_pc      <= '0;
            instr        <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            // A read is in flight exactly when it was issued on the previous edge.
            pending <= imem_en;
            if (imem_en)
                pending_pc <= fetch_pc;

            if (instr_valid && !stall && !redirect_valid && (fetch_count != '1))
                fetch_count <= fetch_count + 32'd1;

            if (state == ST_HALT) begin
                instr_valid <= 1'b0;
                skid_valid  <= 1'b0;
            end else if (redirect_valid) begin
                fetch_pc    <= {redirect_pc[31:2], 2'b00};
                instr_valid <= 1'b0;
                skid_valid  <= 1'b0;
                if (redirect_pc[1:0] != 2'b00)
                    misalign_err <= 1'b1;
            end else if (halt) begin
                instr_valid <= 1'b0;
                skid_valid  <= 1'b0;
                state       <= ST_HALT;
            end else if (stall) begin
                // Memory data lands while the outputs are frozen; park it in the skid.
                if (pending) begin
                    skid_data  <= imem_rdata;
                    skid_pc    <= pending_pc;
                    skid_valid <= 1'b1;
                end
            end else begin
                if (skid_valid) begin
                    instr       <= skid_data;
                    instr_pc    <= skid_pc;
                    instr_valid <= 1'b1;
                    skid_valid  <= pending;
                    if (pending) begin
                        skid_data <= imem_rdata;
                        skid_pc   <= pending_pc;
                    end
                end else if (pending) begin
                    instr       <= imem_rdata;
                    instr_pc    <= pending_pc;
                    instr_valid <= 1'b1;
                end else begin
                    instr_valid <= 1'b0;
                end
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_kgp_risc_fetch.sv
// Self-checking bench for kgp_risc_fetch: scenario tasks plus a scoreboard of
// expected delivered PCs, with a second narrow-memory instance for address wrap.
module tb_kgp_risc_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic        w_imem_en;
    logic [1:0]  w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_instr_valid;
    logic        w_misalign_err;
    logic [31:0] w_fetch_count;

    logic [31:0] mem  [0:1023];
    logic [31:0] wmem [0:3];

    int          checks;
    int          fails;
    logic [31:0] exp_q[$];
    logic [31:0] fc_exp;

    kgp_risc_fetch #(.IMEM_AW(10), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    kgp_risc_fetch #(.IMEM_AW(2), .RESET_PC(32'h0000_0000)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .imem_en(w_imem_en), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_valid(w_instr_valid), .misalign_err(w_misalign_err), .fetch_count(w_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;
        for (int k = 0; k < 4; k++) wmem[k] = 32'h1000_0000 + k;
    end

    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem[imem_addr];
        if (w_imem_en) w_imem_rdata <= wmem[w_imem_addr];
    end

    function automatic logic [31:0] exp_data(input logic [31:0] pc);
        return 32'h1000_0000 + {22'b0, pc[11:2]};
    endfunction

    // Scoreboard: a displayed instruction is consumed on the next edge when not stalled/redirected.
    always @(negedge clk) begin
        if (rst) begin
            fc_exp = '0;
        end else begin
            checks++;
            if (fetch_count !== fc_exp) begin
                fails++;
                $display("FAIL fetch_count: got %0d expected %0d at %0t", fetch_count, fc_exp, $time);
            end
            if (instr_valid && !stall && !redirect_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_underflow: got pc %h, no delivery expected at %0t", instr_pc, $time);
                end else begin
                    logic [31:0] pc;
                    pc = exp_q.pop_front();
                    if (instr_pc !== pc || instr !== exp_data(pc)) begin
                        fails++;
                        $display("FAIL sb_delivery: got pc %h instr %h expected pc %h instr %h",
                                 instr_pc, instr, pc, exp_data(pc));
                    end
                    fc_exp = fc_exp + 32'd1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        stall = 1'b0; redirect_valid = 1'b0; halt = 1'b0; redirect_pc = '0;
        rst = 1'b1;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (instr !== 32'h0 || instr_pc !== 32'h0 || instr_valid !== 1'b0 ||
            misalign_err !== 1'b0 || fetch_count !== 32'h0 || imem_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got instr %h pc %h v %b mis %b fc %0d en %b required all zero",
                     instr, instr_pc, instr_valid, misalign_err, fetch_count, imem_en);
        end
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        rst = 1'b0;
        #1;
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 10'd0) begin
            fails++;
            $display("FAIL first_issue: got en %b addr %0d required 1 0", imem_en, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_1: got valid %b required 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h1000_0000) begin
            fails++;
            $display("FAIL latency_2: got v %b pc %h instr %h required 1 0 10000000",
                     instr_valid, instr_pc, instr);
        end
        tick();
        tick();
        checks++;
        if (instr_pc !== 32'h8) begin
            fails++;
            $display("FAIL seq_pc8: got %h required 00000008", instr_pc);
        end
    endtask

    task automatic test_stall();
        exp_q.push_back(32'hC);
        stall = 1'b1;
        #1;
        checks++;
        if (imem_en !== 1'b0) begin
            fails++;
            $display("FAIL stall_en: got %b required 0", imem_en);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) stall = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== 32'h1000_0002 ||
                (i < 2 && imem_en !== 1'b0)) begin
                fails++;
                $display("FAIL stall_hold: cycle %0d got v %b pc %h instr %h en %b required 1 8 10000002",
                         i, instr_valid, instr_pc, instr, imem_en);
            end
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hC || fetch_count !== 32'd3) begin
            fails++;
            $display("FAIL skid_out: got v %b pc %h fc %0d required 1 c 3", instr_valid, instr_pc, fetch_count);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== 32'h1000_0004 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL after_skid: got v %b pc %h instr %h q %0d required 1 10 10000004 0",
                     instr_valid, instr_pc, instr, exp_q.size());
        end
    endtask

    task automatic test_redirect();
        do_reset();
        exp_q.push_back(32'h0);
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        checks++;
        if (instr_pc !== 32'h4 || imem_en !== 1'b0) begin
            fails++;
            $display("FAIL redir_setup: got pc %h en %b required 4 0", instr_pc, imem_en);
        end
        exp_q.push_back(32'h40);
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || misalign_err !== 1'b0 || imem_addr !== 10'h10) begin
            fails++;
            $display("FAIL redir_squash: got v %b mis %b addr %h required 0 0 10", instr_valid, misalign_err, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_gap: got v %b required 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h1000_0010) begin
            fails++;
            $display("FAIL redir_target: got v %b pc %h instr %h required 1 40 10000010", instr_valid, instr_pc, instr);
        end
        tick();
        checks++;
        if (instr_pc !== 32'h44 || instr !== 32'h1000_0011) begin
            fails++;
            $display("FAIL redir_next: got pc %h instr %h required 44 10000011", instr_pc, instr);
        end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        exp_q.push_back(32'h40);
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (misalign_err !== 1'b1 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL misalign_set: got mis %b v %b required 1 0", misalign_err, instr_valid);
        end
        tick(); tick();
        checks++;
        if (instr_pc !== 32'h40 || instr !== 32'h1000_0010) begin
            fails++;
            $display("FAIL misalign_target: got pc %h instr %h required 40 10000010", instr_pc, instr);
        end
        tick();
        checks++;
        if (misalign_err !== 1'b1) begin
            fails++;
            $display("FAIL misalign_sticky: got %b required 1", misalign_err);
        end
    endtask

    task automatic test_redirect_stall();
        redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h80;
        exp_q.push_back(32'h80); exp_q.push_back(32'h84);
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 10'h20) begin
            fails++;
            $display("FAIL redir_stall: got v %b addr %h required 0 20", instr_valid, imem_addr);
        end
        tick(); tick();
        checks++;
        if (instr_pc !== 32'h80 || instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL redir_stall_target: got pc %h v %b required 80 1", instr_pc, instr_valid);
        end
        tick();
    endtask

    task automatic test_halt();
        halt = 1'b1;
        #1;
        checks++;
        if (imem_en !== 1'b0) begin
            fails++;
            $display("FAIL halt_en: got %b required 0", imem_en);
        end
        tick();
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_valid !== 1'b0 || imem_en !== 1'b0) begin
                fails++;
                $display("FAIL halted: cycle %0d got v %b en %b required 0 0", i, instr_valid, imem_en);
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || instr_pc !== 32'h84) begin
            fails++;
            $display("FAIL halt_frozen: got q %0d pc %h required 0 84", exp_q.size(), instr_pc);
        end
        do_reset();
        checks++;
        if (misalign_err !== 1'b0 || fetch_count !== 32'h0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset: got mis %b fc %0d v %b required 0 0 0", misalign_err, fetch_count, instr_valid);
        end
        exp_q.push_back(32'h0);
        tick(); tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL halt_restart: got v %b pc %h required 1 0", instr_valid, instr_pc);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(k * 4));
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (w_imem_addr !== 2'(k)) begin
                fails++;
                $display("FAIL wrap_addr: edge %0d got %0d required %0d", k, w_imem_addr, k % 4);
            end
        end
        tick();
        checks++;
        if (w_instr_pc !== 32'hC || w_instr !== 32'h1000_0003) begin
            fails++;
            $display("FAIL wrap_pc12: got pc %h instr %h required c 10000003", w_instr_pc, w_instr);
        end
        tick();
        checks++;
        if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'h10 || w_instr !== 32'h1000_0000 ||
            w_fetch_count !== 32'd4 || w_misalign_err !== 1'b0) begin
            fails++;
            $display("FAIL wrap_pc16: got v %b pc %h instr %h fc %0d mis %b required 1 10 10000000 4 0",
                     w_instr_valid, w_instr_pc, w_instr, w_fetch_count, w_misalign_err);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending required 0", exp_q.size());
        end
    endtask

    initial begin
        checks = 0; fails = 0; fc_exp = '0;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; halt = 1'b0; redirect_pc = '0;
        test_reset();
        test_stall();
        test_redirect();
        test_misalign();
        test_redirect_stall();
        test_halt();
        test_wrap();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
